mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single shared line-fill memory port.
- Requesters: instruction cache (read-only) and data cache (read and write).
- Converts level-held requests into the edge-triggered rd/wr protocol of the memory port.
- Holds reads until the memory reports data-valid, and returns a single-cycle completion pulse to the granted requester.

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a single shared
// line-fill memory port.
//
// Requesters hold level requests until their completion pulse. The memory
// port acts on rising edges of mem_rd / mem_wr, so every access is followed
// by a one-cycle GAP with both strobes low.
//
// Build options:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration (1-bit last-grant pointer)
//                  undefined -> fixed priority, dcache over icache
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   ic_addr, ic_rd        icache read request (level)
//   ic_rdata, ic_dv       icache line data / one-cycle completion pulse
//   dc_addr, dc_wdata,
//   dc_len, dc_rd, dc_wr  dcache request (level); write wins over read
//   dc_rdata, dc_dv       dcache line data / completion pulse (reads and writes)
//   mem_addr, mem_wdata,
//   mem_len, mem_rd,
//   mem_wr                memory request, all registered
//   mem_rdata, mem_dv     memory line data / one-cycle data-valid
module mem_arbiter #(
  parameter int LINE_W = 512,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_rd,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_dv,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic [1:0]        dc_len,
  input  logic              dc_rd,
  input  logic              dc_wr,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_dv,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_len,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_dv
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    WR_PULSE = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam logic PORT_IC = 1'b0;
  localparam logic PORT_DC = 1'b1;

  state_t            state_r;
  state_t            state_s;
  logic              owner_r;
  logic              owner_s;
  logic              dc_win_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [1:0]        mem_len_s;
  logic              mem_rd_s;
  logic              mem_wr_s;
  logic [LINE_W-1:0] ic_rdata_s;
  logic [LINE_W-1:0] dc_rdata_s;
  logic              ic_dv_s;
  logic              dc_dv_s;

`ifdef MEM_ARB_RR_EN
  logic last_r;
  logic last_s;

  // Round-robin winner: on contention the port not granted last time wins.
  always_comb begin
    if ((dc_rd | dc_wr) & ic_rd) begin
      dc_win_s = (last_r == PORT_IC);
    end else begin
      dc_win_s = dc_rd | dc_wr;
    end
  end
`else
  // Fixed-priority winner: any dcache request beats the icache.
  always_comb begin
    dc_win_s = dc_rd | dc_wr;
  end
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    mem_len_s   = mem_len;
    mem_rd_s    = mem_rd;
    mem_wr_s    = mem_wr;
    ic_rdata_s  = ic_rdata;
    dc_rdata_s  = dc_rdata;
    ic_dv_s     = 1'b0;
    dc_dv_s     = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_s      = last_r;
`endif
    case (state_r)
      IDLE: begin
        if (dc_win_s) begin
          owner_s     = PORT_DC;
          mem_addr_s  = dc_addr;
          mem_wdata_s = dc_wdata;
          mem_len_s   = dc_len;
`ifdef MEM_ARB_RR_EN
          last_s      = PORT_DC;
`endif
          // A simultaneous dc_rd is ignored when dc_wr is also high.
          if (dc_wr) begin
            mem_wr_s = 1'b1;
            state_s  = WR_PULSE;
          end else begin
            mem_rd_s = 1'b1;
            state_s  = RD_WAIT;
          end
        end else if (ic_rd) begin
          owner_s     = PORT_IC;
          mem_addr_s  = ic_addr;
          mem_wdata_s = {DATA_W{1'b0}};
          mem_len_s   = 2'd0;
          mem_rd_s    = 1'b1;
          state_s     = RD_WAIT;
`ifdef MEM_ARB_RR_EN
          last_s      = PORT_IC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        // Address and strobe stay put until data arrives; no timeout.
        if (mem_dv) begin
          mem_rd_s = 1'b0;
          state_s  = GAP;
          if (owner_r == PORT_DC) begin
            dc_rdata_s = mem_rdata;
            dc_dv_s    = 1'b1;
          end else begin
            ic_rdata_s = mem_rdata;
            ic_dv_s    = 1'b1;
          end
        end else begin
          state_s = RD_WAIT;
        end
      end
      WR_PULSE: begin
        mem_wr_s = 1'b0;
        dc_dv_s  = 1'b1;
        state_s  = GAP;
      end
      GAP: begin
        // Strobes low for a cycle so the next access produces a rising edge.
        mem_rd_s = 1'b0;
        mem_wr_s = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        mem_rd_s = 1'b0;
        mem_wr_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      owner_r   <= PORT_IC;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_len   <= 2'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      ic_rdata  <= {LINE_W{1'b0}};
      dc_rdata  <= {LINE_W{1'b0}};
      ic_dv     <= 1'b0;
      dc_dv     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_r    <= PORT_IC;
`endif
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      mem_len   <= mem_len_s;
      mem_rd    <= mem_rd_s;
      mem_wr    <= mem_wr_s;
      ic_rdata  <= ic_rdata_s;
      dc_rdata  <= dc_rdata_s;
      ic_dv     <= ic_dv_s;
      dc_dv     <= dc_dv_s;
`ifdef MEM_ARB_RR_EN
      last_r    <= last_s;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: testbench for mem_arbiter with a memory model of about
// 8 cycles read delay, a reference model of the grant order and memory
// contents, and a scoreboard monitor that checks every completion pulse.
module tb_mem_arbiter;
  localparam int LINE_W = 512;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int NBYTES = LINE_W / 8;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_rd;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_dv;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [1:0]        dc_len;
  logic              dc_rd;
  logic              dc_wr;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_dv;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_len;
  logic              mem_rd;
  logic              mem_wr;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_dv = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_addr(ic_addr), .ic_rd(ic_rd), .ic_rdata(ic_rdata), .ic_dv(ic_dv),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_len(dc_len), .dc_rd(dc_rd),
    .dc_wr(dc_wr), .dc_rdata(dc_rdata), .dc_dv(dc_dv),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_dv(mem_dv)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pre_byte(input int i);
    return 8'((i * 37) ^ (i >> 2) ^ 90);
  endfunction

  // ---------------- memory model (environment) ----------------
  logic [7:0]  mem_arr [0:4095];
  logic        mem_init = 1'b0;
  logic        mrd_q = 1'b0;
  logic        mwr_q = 1'b0;
  logic        rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [11:0] rd_line = '0;

  always @(posedge clk) begin
    mrd_q  <= mem_rd;
    mwr_q  <= mem_wr;
    mem_dv <= 1'b0;
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= pre_byte(i);
      mem_init <= 1'b1;
    end else begin
      if (mem_wr && !mwr_q) begin
        for (int i = 0; i < 8; i++)
          if (i < (1 << mem_len)) mem_arr[mem_addr[11:0] + 12'(i)] <= mem_wdata[8*i +: 8];
      end
      if (mem_rd && !mrd_q) begin
        rd_pend <= 1'b1;
        rd_cnt  <= 8;
        rd_line <= {mem_addr[11:6], 6'd0};
      end else if (rd_pend) begin
        if (rd_cnt == 1) begin
          rd_pend <= 1'b0;
          mem_dv  <= 1'b1;
          for (int i = 0; i < NBYTES; i++) mem_rdata[8*i +: 8] <= mem_arr[rd_line + 12'(i)];
        end
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    bit                is_dc;
    bit                is_wr;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_arr [0:4095];
  bit         last_dc = 1'b0;  // 1 when the dcache received the latest grant

  function automatic logic [LINE_W-1:0] ref_line(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < NBYTES; i++) l[8*i +: 8] = ref_arr[{a[11:6], 6'd0} + 12'(i)];
    return l;
  endfunction

  task automatic push_grant(input bit is_dc, input bit is_wr, input logic [63:0] a,
                            input logic [63:0] d, input logic [1:0] len);
    exp_t e;
    e.is_dc = is_dc;
    e.is_wr = is_wr;
    e.data  = '0;
    if (is_wr) begin
      for (int i = 0; i < (1 << len); i++) ref_arr[a[11:0] + 12'(i)] = d[8*i +: 8];
    end else begin
      e.data = ref_line(a);
    end
    sb.push_back(e);
    last_dc = is_dc;
  endtask

  // dc_op: 0 none, 1 read, 2 write, 3 read and write raised together
  task automatic txn(input bit ic_en, input int dc_op, input logic [63:0] ia,
                     input logic [63:0] da, input logic [63:0] wd, input logic [1:0] len);
    bit dc_en;
    bit dc_w;
    bit dc_first;
    int steps;
    dc_en = (dc_op != 0);
    dc_w  = (dc_op >= 2);
    dc_first = dc_en;
`ifdef MEM_ARB_RR_EN
    if (ic_en && dc_en) dc_first = !last_dc;
`endif
    if (dc_first) push_grant(1'b1, dc_w, da, wd, len);
    if (ic_en) push_grant(1'b0, 1'b0, ia, 64'd0, 2'd0);
    if (dc_en && !dc_first) push_grant(1'b1, dc_w, da, wd, len);

    ic_addr = ia; dc_addr = da; dc_wdata = wd; dc_len = len;
    ic_rd = ic_en;
    dc_rd = (dc_op == 1) || (dc_op == 3);
    dc_wr = dc_w;
    @(posedge clk); #1;
    steps = 1;
    if (ic_en != dc_en) begin
      check("req_to_mem_rd", LINE_W'(mem_rd), LINE_W'(!dc_w));
      check("req_to_mem_wr", LINE_W'(mem_wr), LINE_W'(dc_w));
      check("mem_addr", LINE_W'(mem_addr), LINE_W'(dc_en ? da : ia));
      if (dc_w) begin
        check("mem_wdata", LINE_W'(mem_wdata), LINE_W'(wd));
        check("mem_len", LINE_W'(mem_len), LINE_W'(len));
      end
    end
    while ((ic_rd || dc_rd || dc_wr) && steps < 100) begin
      @(posedge clk); #1;
      steps++;
      if (ic_dv) ic_rd = 1'b0;
      if (dc_dv) begin
        if (!ic_en && dc_w) check("wr_to_dc_dv", LINE_W'(steps), LINE_W'(2));
        dc_rd = 1'b0;
        dc_wr = 1'b0;
      end
    end
    if (ic_rd || dc_rd || dc_wr) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_timeout: requests ic=%b dcr=%b dcw=%b still pending after %0d cycles",
               ic_rd, dc_rd, dc_wr, steps);
      ic_rd = 1'b0; dc_rd = 1'b0; dc_wr = 1'b0;
    end
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [LINE_W-1:0] mon_ic;
    logic [LINE_W-1:0] mon_dc;
    logic [ADDR_W-1:0] paddr;
    logic pmem_rd, pmem_wr, pdv, dv_due;
    exp_t e;
    mon_ic = '0; mon_dc = '0; paddr = '0;
    pmem_rd = 1'b0; pmem_wr = 1'b0; pdv = 1'b0; dv_due = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_ic = '0;
        mon_dc = '0;
      end else begin
        if (dv_due) check("mem_dv_to_dv", LINE_W'(ic_dv | dc_dv), LINE_W'(1));
        if ((mem_rd && !pmem_rd) || (mem_wr && !pmem_wr))
          check("strobe_gap", LINE_W'(pmem_rd | pmem_wr), LINE_W'(0));
        if (mem_wr) check("mem_wr_width", LINE_W'(pmem_wr), LINE_W'(0));
        if (mem_rd && pmem_rd) check("mem_addr_hold", LINE_W'(mem_addr), LINE_W'(paddr));
        if (ic_dv || dc_dv) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_dv: ic_dv=%b dc_dv=%b with nothing outstanding", ic_dv, dc_dv);
          end else begin
            e = sb.pop_front();
            check("dv_port", LINE_W'({dc_dv, ic_dv}), LINE_W'(e.is_dc ? 2'b10 : 2'b01));
            check("dv_width", LINE_W'(pdv), LINE_W'(0));
            check("mem_rd_dropped", LINE_W'(mem_rd), LINE_W'(0));
            if (e.is_dc && !e.is_wr) mon_dc = e.data;
            else if (!e.is_dc) mon_ic = e.data;
            check("ic_rdata", ic_rdata, mon_ic);
            check("dc_rdata", dc_rdata, mon_dc);
          end
        end
      end
      dv_due  = rst_n && mem_dv && mem_rd;
      pmem_rd = mem_rd;
      pmem_wr = mem_wr;
      pdv     = ic_dv | dc_dv;
      paddr   = mem_addr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int op;
    bit ie;
    int dop;
    logic [63:0] ra, rb, rw;
    logic [1:0] rl;
    for (int i = 0; i < 4096; i++) ref_arr[i] = pre_byte(i);
    rst_n = 1'b0; ic_rd = 1'b0; dc_rd = 1'b0; dc_wr = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; dc_len = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_rd", LINE_W'(mem_rd), LINE_W'(0));
    check("rst_mem_wr", LINE_W'(mem_wr), LINE_W'(0));
    check("rst_mem_addr", LINE_W'(mem_addr), LINE_W'(0));
    check("rst_mem_wdata", LINE_W'(mem_wdata), LINE_W'(0));
    check("rst_mem_len", LINE_W'(mem_len), LINE_W'(0));
    check("rst_ic_dv", LINE_W'(ic_dv), LINE_W'(0));
    check("rst_dc_dv", LINE_W'(dc_dv), LINE_W'(0));
    check("rst_ic_rdata", ic_rdata, LINE_W'(0));
    check("rst_dc_rdata", dc_rdata, LINE_W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single icache read
    txn(1'b1, 0, BASE + 64'h40, 64'd0, 64'd0, 2'd0);
    // dcache write then read of the same address
    txn(1'b0, 2, 64'd0, BASE + 64'h100, 64'hDEADBEEF_CAFEF00D, 2'd3);
    txn(1'b0, 1, 64'd0, BASE + 64'h100, 64'd0, 2'd0);
    check("wr_rd_low64", LINE_W'(dc_rdata[63:0]), LINE_W'(64'hDEADBEEF_CAFEF00D));
    // repeated contention
    for (int k = 0; k < 3; k++) txn(1'b1, 1, BASE + 64'h200, BASE + 64'h240, 64'd0, 2'd0);
    // four back-to-back byte writes, then read the line back
    for (int k = 0; k < 4; k++)
      txn(1'b0, 2, 64'd0, BASE + 64'(k), 64'($urandom_range(0, 255)), 2'd0);
    txn(1'b0, 1, 64'd0, BASE, 64'd0, 2'd0);
    // dc_rd and dc_wr together: the write is performed
    txn(1'b0, 3, 64'd0, BASE + 64'h308, 64'h0123_4567_89AB_CDEF, 2'd2);
    txn(1'b0, 1, 64'd0, BASE + 64'h300, 64'd0, 2'd0);

    // reset in the middle of a read; the stray mem_dv must be ignored
    ic_addr = BASE + 64'h380;
    ic_rd = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rd_wait_entered", LINE_W'(mem_rd), LINE_W'(1));
    rst_n = 1'b0;
    ic_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_mem_rd", LINE_W'(mem_rd), LINE_W'(0));
    check("midrst_mem_wr", LINE_W'(mem_wr), LINE_W'(0));
    check("midrst_ic_dv", LINE_W'(ic_dv), LINE_W'(0));
    check("midrst_dc_dv", LINE_W'(dc_dv), LINE_W'(0));
    check("midrst_ic_rdata", ic_rdata, LINE_W'(0));
    repeat (15) @(posedge clk);
    #1;
    txn(1'b1, 0, BASE + 64'h380, 64'd0, 64'd0, 2'd0);

    // randomized mix
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 5);
      ie = (op == 0) || (op == 3) || (op == 4);
      dop = (op == 0) ? 0 : ((op == 1) || (op == 3)) ? 1 : ((op == 2) || (op == 4)) ? 2 : 3;
      ra = BASE | 64'($urandom_range(0, 1023));
      rb = BASE | 64'($urandom_range(0, 1023));
      rw = {32'($urandom), 32'($urandom)};
      rl = 2'($urandom_range(0, 3));
      txn(ie, dop, ra, rb, rw, rl);
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", LINE_W'(sb.size()), LINE_W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
